// File: rtl/hazard_if.sv
// Pipeline hazard interface: EX/ID operand info and divider handshake in,
// stall vector, watchdog flag, perf count and FSM state debug out.
interface hazard_if;
  logic        ex_is_load;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        div_start;
  logic        div_ready;
  logic [5:0]  stall;
  logic        div_timeout;
  logic [31:0] stall_cycles;
  logic        state_dbg;

  // Divider handshake: div_start is a one-cycle issue pulse accepted only in RUN;
  // div_ready (pulse or level) completes the wait and is ignored outside DIV_WAIT.
  modport master (
    output ex_is_load, ex_rf_we, ex_rf_waddr, id_re1, id_re2, id_raddr1, id_raddr2,
           div_start, div_ready,
    input  stall, div_timeout, stall_cycles, state_dbg
  );

  modport slave (
    input  ex_is_load, ex_rf_we, ex_rf_waddr, id_re1, id_re2, id_raddr1, id_raddr2,
           div_start, div_ready,
    output stall, div_timeout, stall_cycles, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use and multi-cycle divide hazard controller with divider watchdog.
// Optional macro HAZARD_PERF_EN adds a saturating PC-stall cycle counter.
module hazard_ctrl (
  input  logic    clk,
  input  logic    rst_n,
  hazard_if.slave hif
);
  typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [5:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;
  logic [5:0] stall_raw;
  logic       lu_hit;

  assign lu_hit = hif.ex_is_load & hif.ex_rf_we & (hif.ex_rf_waddr != 5'd0) &
                  ((hif.id_re1 & (hif.id_raddr1 == hif.ex_rf_waddr)) |
                   (hif.id_re2 & (hif.id_raddr2 == hif.ex_rf_waddr)));

  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    stall_raw = 6'b000000;
    case (state_q)
      RUN: begin
        if (hif.div_start) begin
          stall_raw = 6'b001111;
          state_d   = DIV_WAIT;
          wd_cnt_d  = 6'd0;
        end else if (lu_hit) begin
          // Single bubble: the load result is forwarded from MEM next cycle.
          stall_raw = 6'b000111;
        end
      end
      DIV_WAIT: begin
        if (hif.div_ready) begin
          state_d = RUN;
        end else if (wd_cnt_q == 6'd63) begin
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          stall_raw = 6'b001111;
          wd_cnt_d  = wd_cnt_q + 6'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wd_cnt_q  <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Stall is combinational, so reset must mask it directly.
  assign hif.stall       = rst_n ? stall_raw : 6'b000000;
  assign hif.div_timeout = timeout_q;
  assign hif.state_dbg   = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (hif.stall[0] && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= 32'd0;
    else        perf_q <= perf_d;
  end

  assign hif.stall_cycles = perf_q;
`else
  assign hif.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized-address bench for hazard_ctrl with an expected-value queue.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_perf = 0;
  logic [39:0] exp_q[$];

  hazard_if hif ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] perf_now();
`ifdef HAZARD_PERF_EN
    return exp_perf;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_pop(input string tag);
    logic [39:0] e;
    e = exp_q.pop_front();
    total++;
    assert (hif.stall === e[39:34]) else begin
      bad++; $error("FAIL %s stall observed=%b expected=%b", tag, hif.stall, e[39:34]);
    end
    total++;
    assert (hif.div_timeout === e[33]) else begin
      bad++; $error("FAIL %s div_timeout observed=%b expected=%b", tag, hif.div_timeout, e[33]);
    end
    total++;
    assert (hif.state_dbg === e[32]) else begin
      bad++; $error("FAIL %s state observed=%b expected=%b", tag, hif.state_dbg, e[32]);
    end
    total++;
    assert (hif.stall_cycles === e[31:0]) else begin
      bad++; $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, hif.stall_cycles, e[31:0]);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, check at negedge.
  task automatic drive(input string tag, input logic ld, input logic we, input logic [4:0] wa,
                       input logic re1, input logic [4:0] ra1, input logic re2,
                       input logic [4:0] ra2, input logic ds, input logic dr,
                       input logic [5:0] es, input logic et, input logic est);
    hif.ex_is_load = ld; hif.ex_rf_we = we; hif.ex_rf_waddr = wa;
    hif.id_re1 = re1; hif.id_raddr1 = ra1; hif.id_re2 = re2; hif.id_raddr2 = ra2;
    hif.div_start = ds; hif.div_ready = dr;
    exp_q.push_back({es, et, est, perf_now()});
    @(negedge clk);
    check_pop(tag);
    @(posedge clk);
    if (es[0]) exp_perf++;
    #1;
  endtask

  task automatic idle(input string tag, input logic dr, input logic [5:0] es,
                      input logic et, input logic est);
    drive(tag, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, dr, es, et, est);
  endtask

  task automatic reset_check(input string tag);
    exp_q.push_back({6'b000000, 1'b0, 1'b0, 32'd0});
    #1;
    check_pop(tag);
  endtask

  initial begin
    logic [4:0] wa;
    logic [4:0] other;
    // Reset asserted with a load-use hit and div_start on the inputs.
    hif.ex_is_load = 1; hif.ex_rf_we = 1; hif.ex_rf_waddr = 5'd5;
    hif.id_re1 = 1; hif.id_raddr1 = 5'd5; hif.id_re2 = 0; hif.id_raddr2 = 5'd0;
    hif.div_start = 1; hif.div_ready = 0;
    reset_check("reset_state");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    idle("idle", 0, 6'b000000, 0, 0);
    drive("lu_rs1", 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 6'b000111, 0, 0);
    idle("lu_bubble", 0, 6'b000000, 0, 0);
    drive("lu_x0", 1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 6'b000000, 0, 0);
    drive("lu_re1_off", 1, 1, 5'd5, 0, 5'd5, 0, 5'd0, 0, 0, 6'b000000, 0, 0);
    drive("lu_no_we", 1, 0, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 6'b000000, 0, 0);
    drive("lu_not_load", 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 6'b000000, 0, 0);
    drive("lu_rs2", 1, 1, 5'd9, 0, 5'd9, 1, 5'd9, 0, 0, 6'b000111, 0, 0);
    idle("ready_in_run", 1, 6'b000000, 0, 0);

    for (int i = 0; i < 6; i++) begin
      wa = 5'($urandom_range(1, 31));
      other = wa ^ 5'($urandom_range(1, 31));
      drive("rand_hit", 1, 1, wa, 1, other, 1, wa, 0, 0, 6'b000111, 0, 0);
      drive("rand_miss", 1, 1, wa, 1, other, 1, other, 0, 0, 6'b000000, 0, 0);
    end

    // Divide completing after 10 wait cycles; hazards during the wait are ignored.
    drive("div_start", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 6'b001111, 0, 0);
    for (int i = 0; i < 10; i++)
      drive("div_wait", 1, 1, 5'd3, 1, 5'd3, 0, 5'd0, i[0], 0, 6'b001111, 0, 1);
    idle("div_ready", 1, 6'b000000, 0, 1);
    idle("div_back_run", 0, 6'b000000, 0, 0);
    drive("lu_after_div", 1, 1, 5'd7, 1, 5'd7, 0, 5'd0, 0, 0, 6'b000111, 0, 0);

    // Watchdog: no ready ever arrives.
    drive("wd_start", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 6'b001111, 0, 0);
    for (int i = 0; i < 63; i++) idle("wd_wait", 0, 6'b001111, 0, 1);
    idle("wd_expire", 0, 6'b000000, 0, 1);
    idle("wd_sticky", 0, 6'b000000, 1, 0);
    drive("lu_after_wd", 1, 1, 5'd4, 0, 5'd0, 1, 5'd4, 0, 0, 6'b000111, 1, 0);
    idle("wd_sticky2", 1, 6'b000000, 1, 0);

    // div_start beats a simultaneous load-use hit; reset abandons the wait.
    drive("div_vs_lu", 1, 1, 5'd6, 1, 5'd6, 0, 5'd0, 1, 0, 6'b001111, 1, 0);
    for (int i = 0; i < 3; i++) idle("div_wait2", 0, 6'b001111, 1, 1);
    hif.ex_is_load = 1; hif.ex_rf_we = 1; hif.ex_rf_waddr = 5'd6;
    hif.id_re1 = 1; hif.id_raddr1 = 5'd6; hif.div_start = 0; hif.div_ready = 0;
    rst_n = 1'b0;
    reset_check("mid_wait_reset");
    @(posedge clk);
    #1; rst_n = 1'b1; exp_perf = 0;
    idle("post_reset_run", 0, 6'b000000, 0, 0);
    idle("post_reset_ready", 1, 6'b000000, 0, 0);

    // One load-use stall plus a 5-cycle divide: 7 PC-stall cycles.
    drive("perf_lu", 1, 1, 5'd2, 1, 5'd2, 0, 5'd0, 0, 0, 6'b000111, 0, 0);
    drive("perf_div", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 6'b001111, 0, 0);
    for (int i = 0; i < 5; i++) idle("perf_wait", 0, 6'b001111, 0, 1);
    idle("perf_ready", 1, 6'b000000, 0, 1);
    @(negedge clk);
    total++;
`ifdef HAZARD_PERF_EN
    assert (hif.stall_cycles === 32'd7) else begin
      bad++; $error("FAIL perf_total observed=%0d expected=7", hif.stall_cycles);
    end
`else
    assert (hif.stall_cycles === 32'd0) else begin
      bad++; $error("FAIL perf_total observed=%0d expected=0", hif.stall_cycles);
    end
`endif
    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
